// File: rtl/alu_operand_collector.sv
// Gathers ALU operand beats from upstream until the command's required set is
// present, then issues a single-cycle CE strobe to the ALU.
module alu_operand_collector #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       in_valid,
  input  logic [WIDTH-1:0] in_opa,
  input  logic [WIDTH-1:0] in_opb,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic             in_mode,
  input  logic             in_cin,
  output logic             in_ready,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [CMD_W-1:0] cmd,
  output logic             mode,
  output logic             cin,
  output logic             ce,
  output logic [1:0]       inp_valid,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   a_q, a_n, b_q, b_n;
  logic [CMD_W-1:0]   cmd_q, cmd_n;
  logic               mode_q, mode_n, cin_q, cin_n;
  logic [1:0]         req_q, req_n, col_q, col_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;

  logic [WIDTH-1:0]   opa_n, opb_n;
  logic [CMD_W-1:0]   cmd_o_n;
  logic               mode_o_n, cin_o_n, ce_n, err_n, ready_n;
  logic [1:0]         inp_valid_n;

  logic [1:0]         req_c;
  logic               legal_c;
  logic               accept_c;

  assign accept_c = (|in_valid) && in_ready;

  // Required operand mask for the incoming command; unknown commands pass through.
  always_comb begin
    req_c   = 2'b00;
    legal_c = 1'b1;
    if (in_mode) begin
      case (in_cmd)
        CMD_W'(0), CMD_W'(1), CMD_W'(2), CMD_W'(3),
        CMD_W'(8), CMD_W'(9), CMD_W'(10):             req_c = 2'b11;
        CMD_W'(4), CMD_W'(5):                         req_c = 2'b01;
        CMD_W'(6), CMD_W'(7):                         req_c = 2'b10;
        default:                                      legal_c = 1'b0;
      endcase
    end else begin
      case (in_cmd)
        CMD_W'(0), CMD_W'(1), CMD_W'(2), CMD_W'(3),
        CMD_W'(4), CMD_W'(5), CMD_W'(12), CMD_W'(13): req_c = 2'b11;
        CMD_W'(6), CMD_W'(8), CMD_W'(9):              req_c = 2'b01;
        CMD_W'(7), CMD_W'(10), CMD_W'(11):            req_c = 2'b10;
        default:                                      legal_c = 1'b0;
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    a_n         = a_q;
    b_n         = b_q;
    cmd_n       = cmd_q;
    mode_n      = mode_q;
    cin_n       = cin_q;
    req_n       = req_q;
    col_n       = col_q;
    cnt_n       = cnt_q;
    err_n       = 1'b0;
    opa_n       = opa;
    opb_n       = opb;
    cmd_o_n     = cmd;
    mode_o_n    = mode;
    cin_o_n     = cin;
    ce_n        = 1'b0;
    inp_valid_n = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cmd_n  = in_cmd;
          mode_n = in_mode;
          cin_n  = in_cin;
          if (in_valid[0]) a_n = in_opa;
          if (in_valid[1]) b_n = in_opb;
          col_n  = in_valid;
          req_n  = legal_c ? req_c : in_valid;
          cnt_n  = '0;
          state_n = ((col_n & req_n) == req_n) ? S_ISSUE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (accept_c) begin
          if (in_valid[0]) a_n = in_opa;
          if (in_valid[1]) b_n = in_opb;
          col_n = col_q | in_valid;
        end
        // Completion takes priority over an expiring counter.
        if ((col_n & req_q) == req_q) begin
          state_n = S_ISSUE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
        end
      end
      S_ISSUE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Issue fields are loaded on the edge entering ISSUE so CE appears one clock after the completing beat.
    if (state_n == S_ISSUE) begin
      ce_n        = 1'b1;
      inp_valid_n = req_n;
      opa_n       = req_n[0] ? a_n : '0;
      opb_n       = req_n[1] ? b_n : '0;
      cmd_o_n     = cmd_n;
      mode_o_n    = mode_n;
      cin_o_n     = cin_n;
    end

    ready_n = (state_n != S_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      req_q       <= 2'b00;
      col_q       <= 2'b00;
      cnt_q       <= '0;
      opa         <= '0;
      opb         <= '0;
      cmd         <= '0;
      mode        <= 1'b0;
      cin         <= 1'b0;
      ce          <= 1'b0;
      inp_valid   <= 2'b00;
      timeout_err <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      state_q     <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      cmd_q       <= cmd_n;
      mode_q      <= mode_n;
      cin_q       <= cin_n;
      req_q       <= req_n;
      col_q       <= col_n;
      cnt_q       <= cnt_n;
      opa         <= opa_n;
      opb         <= opb_n;
      cmd         <= cmd_o_n;
      mode        <= mode_o_n;
      cin         <= cin_o_n;
      ce          <= ce_n;
      inp_valid   <= inp_valid_n;
      timeout_err <= err_n;
      in_ready    <= ready_n;
    end
  end

endmodule
